// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Holds the program counter, addresses the
// combinational instruction ROM, and registers the returned word into the
// IF/ID pipeline register. Supports stall, redirect (branch/jump), halt on the
// all-ones sentinel word, and a saturating count of delivered instructions.
//
// Ports
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous active-high reset
//   rom_addr     out  ADDR_W  ROM word address, pc[ADDR_W+1:2]
//   rom_instr    in   32      ROM data, combinational from rom_addr
//   stall        in   1       hold PC and IF/ID
//   redirect     in   1       taken branch/jump, load redirect_pc
//   redirect_pc  in   32      byte target PC (bits [1:0] ignored)
//   if_id_instr  out  32      registered instruction to decode
//   if_id_pc     out  32      byte PC of if_id_instr
//   if_id_valid  out  1       if_id_instr is a real fetched instruction
//   halted       out  1       stage is in the HALTED state
//   fetch_count  out  16      valid instructions delivered, saturating
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013,
    parameter logic [31:0] HALT     = 32'hffff_ffff
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_instr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc,
    output logic              if_id_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;

    logic        out_of_range_s;
    logic [31:0] fw_s;

    // PCs beyond the ROM behave as if they fetched the halt word.
    assign out_of_range_s = |pc_q[31:ADDR_W+2];
    assign fw_s           = out_of_range_s ? HALT : rom_instr;

    assign rom_addr    = pc_q[ADDR_W+1:2];
    assign if_id_instr = instr_q;
    assign if_id_pc    = ifpc_q;
    assign if_id_valid = valid_q;
    assign fetch_count = count_q;
    assign halted      = (state_q == ST_HALTED);

    // Next-state logic: redirect > halted hold > stall > fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        count_d = count_q;
        if (redirect) begin
            // Flush the slot; if_id_pc intentionally keeps its old value.
            pc_d    = redirect_pc & 32'hffff_fffc;
            instr_d = NOP;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                ST_RUN: begin
                    if (stall) begin
                        state_d = ST_RUN;
                    end else if (fw_s == HALT) begin
                        // Park on the halt address; the halt word never goes downstream.
                        state_d = ST_HALTED;
                        instr_d = NOP;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = fw_s;
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        if (count_q != 16'hffff) begin
                            count_d = count_q + 16'd1;
                        end else begin
                            count_d = count_q;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            ifpc_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

endmodule
